// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and defaults for the serial-in parallel-out framer.
//   state_e    : frame controller states (IDLE / SHIFT)
//   DEF_WIDTH  : default number of bits per word
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_shreg.sv
// sipo_shreg: WIDTH-bit right-shift register. New bits enter at the MSB,
// so after WIDTH shifts the first bit received sits in bit 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (has priority over shift)
//   en_i       : shift enable
//   d_i        : serial input bit
//   q_o        : current register contents
module sipo_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (clr_i)
            sreg_d = '0;
        else if (en_i)
            sreg_d = {d_i, sreg_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sreg_q <= '0;
        else
            sreg_q <= sreg_d;
    end

    assign q_o = sreg_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames a strobed serial bit stream into WIDTH-bit words and
// offers each word to a consumer over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin (or restart) a frame
//   bit_en     : sdata is valid this cycle
//   sdata      : serial data bit
//   word       : captured parallel word (first received bit in word[0])
//   valid      : word holds an unconsumed frame
//   ready      : consumer takes word when valid && ready
//   busy       : a frame is being shifted in
//   overrun    : sticky, a completed frame was dropped because word was full
//   clr_ovr    : clears overrun (a simultaneous new overrun wins)
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_en,
    input  logic             sdata,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             shift_en, sclr, complete;
    logic [WIDTH-1:0] sreg_q, new_frame;
    logic             sreg_lsb_unused;

    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (sclr),
        .en_i  (shift_en),
        .d_i   (sdata),
        .q_o   (sreg_q)
    );

    // Completed frame includes the bit arriving this cycle; the old LSB is
    // the one being shifted out and is not part of the word.
    assign new_frame       = {sdata, sreg_q[WIDTH-1:1]};
    assign sreg_lsb_unused = sreg_q[0];

    // Controller FSM and bit counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        sclr     = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sclr    = 1'b1;
                end
            end
            SHIFT: begin
                // start beats a completing bit: the partial frame is dropped
                if (start) begin
                    cnt_d = '0;
                    sclr  = 1'b1;
                end else if (bit_en) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register, handshake and overrun
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && ready)
            valid_d = 1'b0;
        if (clr_ovr)
            ovr_d = 1'b0;
        if (complete) begin
            // The slot is free if empty or being drained this same cycle
            if (!valid_q || ready) begin
                word_d  = new_frame;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word    = word_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, bit_en = 1'b0, sdata = 1'b0, ready = 1'b0, clr_ovr = 1'b0;
    logic [W-1:0] word;
    logic         valid, busy, overrun;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame as a list of received bits
    bit m_busy, m_valid, m_ovr;
    int m_word;
    int m_bits[$];

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bit_en  (bit_en),
        .sdata   (sdata),
        .word    (word),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .overrun (overrun),
        .clr_ovr (clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_valid = 0; m_ovr = 0; m_word = 0;
        m_bits.delete();
    endfunction

    function automatic void model_step(bit s, bit be, bit sd, bit rd, bit co);
        bit old_valid = m_valid;
        bit cap = 0, set_ovr = 0;
        int frame;
        if (s) begin
            m_busy = 1;
            m_bits.delete();
        end else if (m_busy && be) begin
            m_bits.push_back(int'(sd));
            if (m_bits.size() == W) begin
                frame = 0;
                foreach (m_bits[i]) frame += m_bits[i] * (1 << i);
                m_bits.delete();
                m_busy = 0;
                if (!old_valid || rd) begin
                    m_word = frame;
                    cap = 1;
                end else begin
                    set_ovr = 1;
                end
            end
        end
        if (cap) m_valid = 1;
        else if (old_valid && rd) m_valid = 0;
        if (set_ovr) m_ovr = 1;
        else if (co) m_ovr = 0;
    endfunction

    task automatic check_outputs();
        chk("word", int'(word), m_word);
        chk("valid", int'(valid), int'(m_valid));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("busy", int'(busy), int'(m_busy));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic cyc(input bit s, input bit be, input bit sd, input bit rd, input bit co);
        start = s; bit_en = be; sdata = sd; ready = rd; clr_ovr = co;
        @(posedge clk);
        model_step(s, be, sd, rd, co);
        #1;
        check_outputs();
    endtask

    // Send a whole frame of bits (LSB-first list), bit_en every 'gap' cycles
    task automatic send(input logic [W-1:0] bits, input int gap, input bit rd_last);
        for (int i = 0; i < W; i++) begin
            for (int g = 1; g < gap; g++) cyc(0, 0, 1, 0, 0);
            cyc(0, 1, bits[i], (i == W-1) ? rd_last : 1'b0, 0);
        end
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_valid", int'(valid), 0);
        chk("reset_word", int'(word), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ovr", int'(overrun), 0);
        rst_n = 1'b1;

        // 1: basic frame, bits 1,0,1,1
        cyc(1, 0, 0, 0, 0);
        send(4'b1101, 1, 0);
        chk("t1_word", int'(word), 'b1101);
        chk("t1_valid", int'(valid), 1);
        chk("t1_busy", int'(busy), 0);
        cyc(0, 0, 0, 1, 0);  // drain

        // 2: gapped strobes with ready held; valid lasts one cycle
        start = 1; ready = 1;
        cyc(1, 0, 0, 1, 0);
        for (int i = 0; i < W; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 1, 1, 0);
            cyc(0, 1, ((4'b1101 >> i) & 1) != 0, 1, 0);
        end
        chk("t2_word", int'(word), 'b1101);
        chk("t2_valid_hi", int'(valid), 1);
        cyc(0, 0, 0, 1, 0);
        chk("t2_valid_lo", int'(valid), 0);

        // 3: overrun
        cyc(1, 0, 0, 0, 0);
        send(4'b0011, 1, 0);
        cyc(1, 0, 0, 0, 0);
        send(4'b1111, 1, 0);
        chk("t3_word", int'(word), 'b0011);
        chk("t3_ovr", int'(overrun), 1);
        cyc(0, 0, 0, 0, 1);
        chk("t3_clr", int'(overrun), 0);

        // 4: consume and capture in the same cycle
        cyc(1, 0, 0, 0, 0);
        send(4'b1010, 2, 1);
        chk("t4_word", int'(word), 'b1010);
        chk("t4_valid", int'(valid), 1);
        chk("t4_ovr", int'(overrun), 0);
        cyc(0, 0, 0, 1, 0);

        // 5: restart after two bits
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        send(4'b1000, 1, 0);
        chk("t5_word", int'(word), 'b1000);
        chk("t5_ovr", int'(overrun), 0);

        // 6: asynchronous reset mid-frame with valid=1
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        start = 0; bit_en = 0; ready = 0; clr_ovr = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_word", int'(word), 0);
        chk("t6_valid", int'(valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ovr", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0);
        send(4'b0110, 1, 0);
        chk("t6_after", int'(word), 'b0110);
        cyc(0, 0, 0, 1, 0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            bit s;
            s = m_busy ? ($urandom_range(15) == 0) : ($urandom_range(2) == 0);
            cyc(s, $urandom_range(1) == 1, $urandom_range(1) == 1,
                $urandom_range(2) != 0, $urandom_range(7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Controller that sequences a serial-in parallel-out shift path. It frames a serial bit stream into WIDTH-bit words: it gates shifting on a per-bit strobe, counts bits, and captures each completed word into an output holding register. The word is presented to a downstream consumer through a valid/ready handshake. It sits between a serial source (pin synchroniser or bit-rate timer) and any parallel consumer, replacing free-running shift registers that have no framing.

## Interface
- WIDTH, default 4: bits per word; legal range 2..32.
- CNT_W, default $clog2(WIDTH): bit counter width (derived; do not override).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start request
- bit_en  in  1  sample strobe; sdata is valid in this cycle
- sdata  in  1  serial data bit
- word  out  WIDTH  captured parallel word
- valid  out  1  word holds an unconsumed frame
- ready  in  1  consumer accepts word when valid && ready
- busy  out  1  frame in progress (state SHIFT)
- overrun  out  1  sticky flag: a completed frame was dropped
- clr_ovr  in  1  synchronous clear of overrun

## Operation
- States: IDLE, SHIFT.
- IDLE: bit_en and sdata are ignored. start=1 moves to SHIFT and clears bit_cnt; no bit is sampled in the start cycle.
- SHIFT, bit_en=1: sreg <= {sdata, sreg[WIDTH-1:1]}, so new bits enter the MSB and the first bit received ends at word[0]. bit_cnt increments.
- Frame completion: bit_en=1 with bit_cnt==WIDTH-1. The shifted value, including the current sdata, is captured, state returns to IDLE, and bit_cnt returns to 0.
- Capture rules at completion:
  - If valid=0, or valid&&ready in the same cycle: word <= new frame, valid stays/goes 1, overrun unchanged.
  - If valid=1 and ready=0: the new frame is discarded, word is unchanged, overrun <= 1.
- Handshake: valid drops the cycle after valid&&ready unless a capture occurs in that cycle. word is stable while valid=1. ready is ignored while valid=0.
- start while in SHIFT restarts the frame: bit_cnt <= 0, the partial frame is discarded, state stays SHIFT, and no overrun is raised. If start and a completing bit_en coincide, start wins and nothing is captured.
- overrun is cleared by clr_ovr. If a set and a clear happen in the same cycle, the set wins.
- busy = (state==SHIFT).
- Reset (asynchronous, any time, including mid-frame): state IDLE, sreg=0, bit_cnt=0, word=0, valid=0, overrun=0, busy=0.

## Timing
- Word latency: word/valid update on the clk edge that samples the final bit_en, i.e. visible 1 cycle after the last bit_en cycle begins.
- Minimum frame length: 1 start cycle + WIDTH bit_en cycles. Back-to-back frames need start in the cycle after completion, so the minimum is WIDTH+1 cycles per word.
- bit_en may be held high continuously (1 bit/clk) or pulsed at any rate; gaps do not affect the count.
- Throughput with ready held at 1: one word per frame, and overrun never sets.
- All outputs are registered except busy, which is decoded from the state register.

## Structure
- Package sipo_pkg:
  - state typedef (IDLE=1'b0, SHIFT=1'b1)
  - default WIDTH constant
- Sub-module sipo_shreg: WIDTH-bit right-shift register with shift enable and synchronous clear; instantiated once for sreg.
- Controller FSM, counter, output register and overrun logic stay in sipo_frame_ctrl.

## Test plan
All scenarios use WIDTH=4.
1. Reset then start; bit_en=1 for 4 cycles with sdata 1,0,1,1 -> word=4'b1101, valid=1 one cycle after the last bit; busy=0.
2. Gapped strobes: same bits with bit_en pulsed every 3rd cycle, ready=1 -> word=4'b1101; valid pulses exactly 1 cycle.
3. Overrun: complete 4'b0011 with ready=0, then complete 4'b1111 -> word stays 4'b0011, overrun=1. Then clr_ovr -> overrun=0.
4. Simultaneous consume and capture: valid=1 and ready=1 in the cycle frame 2 completes (4'b1010) -> word=4'b1010, valid stays 1, overrun=0.
5. Restart: start after 2 bits, then 4 bits 0,0,0,1 -> word=4'b1000; the partial frame is lost and overrun=0.
6. rst_n low for 1 cycle mid-frame (bit_cnt=2) with valid=1 -> all outputs 0 immediately (asynchronous); the next full frame captures correctly.
